// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   REG_ZERO       : hardwired-zero register address
//   WB_ALU/WB_LOAD : write-port indices (ALU writeback, load writeback)
//   NUM_WR         : number of write ports
//   clog2()        : ceiling log2 usable in parameter expressions
package regfile_pkg;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned WB_ALU   = 0;
   localparam int unsigned WB_LOAD  = 1;
   localparam int unsigned NUM_WR   = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Ports:
//   addr        in  AW        read address
//   stored      in  DW        stored value of register addr
//   stored_busy in  1         scoreboard bit of register addr
//   wr_en       in  2         live write enables (already gated by reset)
//   wr_addr     in  2*AW      write addresses
//   wr_data     in  2*DW      write data
//   data        out DW        read data
//   busy        out 1         register has a pending producer
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned BYPASS = 1
) (
   input  logic [AW-1:0]        addr,
   input  logic [DW-1:0]        stored,
   input  logic                 stored_busy,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic [NUM_WR*DW-1:0] wr_data,
   output logic [DW-1:0]        data,
   output logic                 busy
);

   logic byp;
   logic hit_alu;
   logic hit_load;

   assign byp      = (BYPASS != 0);
   assign hit_alu  = wr_en[WB_ALU]  && (wr_addr[WB_ALU*AW  +: AW] == addr);
   assign hit_load = wr_en[WB_LOAD] && (wr_addr[WB_LOAD*AW +: AW] == addr);

   // Zero check, then bypass (load port first), then stored value.
   // A register being written this cycle is reported not busy when bypassing,
   // since the consumer already sees the produced value.
   always_comb begin
      data = stored;
      busy = stored_busy;
      if (addr == AW'(REG_ZERO)) begin
         data = '0;
         busy = 1'b0;
      end else if (byp && hit_load) begin
         data = wr_data[WB_LOAD*DW +: DW];
         busy = 1'b0;
      end else if (byp && hit_alu) begin
         data = wr_data[WB_ALU*DW +: DW];
         busy = 1'b0;
      end
   end

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined MIPS datapath: NUM_RD
// combinational read ports, two clocked write ports, optional write-to-read
// bypass and a per-register busy scoreboard for decode hazard stalls.
// Register 0 reads as zero; all state clears on asynchronous reset.
// Ports:
//   clk        in  1          clock
//   rst_n      in  1          asynchronous active-low reset
//   rd_addr    in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
//   rd_data    out NUM_RD*DW  read data (combinational), port k at [k*DW +: DW]
//   rd_busy    out NUM_RD     port k's register has a pending producer
//   wr_en      in  2          write enables (0 = ALU, 1 = load)
//   wr_addr    in  2*AW       write addresses
//   wr_data    in  2*DW       write data
//   iss_en     in  1          instruction issued with a destination register
//   iss_addr   in  AW         destination of the issued instruction
//   wr_collide out 1          both write ports hit the same nonzero register last cycle
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned AW     = clog2(DEPTH),
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic [NUM_WR*DW-1:0] wr_data,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   output logic                 wr_collide
);

   // Elaboration-time parameter checks.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("regfile_mp: DEPTH must be a power of two >= 2");
   end
   if (AW != clog2(DEPTH)) begin : g_bad_aw
      $error("regfile_mp: AW is derived from DEPTH and must not be overridden");
   end
   if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be 1..4");
   end
   if (BYPASS > 1) begin : g_bad_bypass
      $error("regfile_mp: BYPASS must be 0 or 1");
   end

   logic [DW-1:0]     regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              collide_nxt;
   logic [NUM_WR-1:0] wr_live;
   logic [NUM_WR-1:0] wr_ok;
   logic [AW-1:0]     wa [NUM_WR];
   logic [DW-1:0]     wd [NUM_WR];

   // Writes in flight while reset is held are discarded, so they must not
   // leak through the bypass path either.
   assign wr_live = wr_en & {NUM_WR{rst_n}};

   // Unpack write ports; writes to register 0 are dropped here.
   for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
      assign wa[i]    = wr_addr[i*AW +: AW];
      assign wd[i]    = wr_data[i*DW +: DW];
      assign wr_ok[i] = wr_live[i] && (wa[i] != AW'(REG_ZERO));
   end

   // Storage; the load port is assigned last so it wins on a shared address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else begin
         if (wr_ok[WB_ALU])  regs[wa[WB_ALU]]  <= wd[WB_ALU];
         if (wr_ok[WB_LOAD]) regs[wa[WB_LOAD]] <= wd[WB_LOAD];
      end
   end

   // Scoreboard next state: writebacks clear, then a new issue sets, so the
   // newest producer wins when both land on the same register.
   always_comb begin
      busy_nxt = busy;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_ok[i]) busy_nxt[wa[i]] = 1'b0;
      end
      if (iss_en && (iss_addr != AW'(REG_ZERO))) busy_nxt[iss_addr] = 1'b1;
      busy_nxt[REG_ZERO] = 1'b0;
   end

   // Both ports writing the same nonzero register (wr_ok already excludes r0).
   assign collide_nxt = wr_ok[WB_ALU] && wr_ok[WB_LOAD] && (wa[WB_ALU] == wa[WB_LOAD]);

   // Scoreboard and collision flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         wr_collide <= 1'b0;
      end else begin
         busy       <= busy_nxt;
         wr_collide <= collide_nxt;
      end
   end

   // Read ports.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[k*AW +: AW];

      regfile_rd_port #(
         .DW     (DW),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_rd_port (
         .addr        (addr),
         .stored      (regs[addr]),
         .stored_busy (busy[addr]),
         .wr_en       (wr_live),
         .wr_addr     (wr_addr),
         .wr_data     (wr_data),
         .data        (rd_data[k*DW +: DW]),
         .busy        (rd_busy[k])
      );
   end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing 4-read-port instance and one
// non-bypassing 2-read-port instance share write/issue stimulus.
// Directed vector table, a hand-written asynchronous-reset sequence, then
// random traffic checked against an array-based reference model.
module tb_regfile_mp;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     we;
   logic [AW-1:0]  wa0, wa1, ia;
   logic [DW-1:0]  wd0, wd1;
   logic           ie;
   logic [AW-1:0]  ra [4];

   logic [4*AW-1:0] rd_addr_b;
   logic [2*AW-1:0] rd_addr_n;
   logic [4*DW-1:0] rd_data_b;
   logic [2*DW-1:0] rd_data_n;
   logic [3:0]      rd_busy_b;
   logic [1:0]      rd_busy_n;
   logic            col_b, col_n;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;

   assign rd_addr_b = {ra[3], ra[2], ra[1], ra[0]};
   assign rd_addr_n = {ra[1], ra[0]};
   assign wr_addr   = {wa1, wa0};
   assign wr_data   = {wd1, wd0};

   always #5 clk = ~clk;

   regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(4), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .wr_en(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(ie), .iss_addr(ia), .wr_collide(col_b));

   regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_n), .rd_data(rd_data_n),
      .rd_busy(rd_busy_n), .wr_en(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(ie), .iss_addr(ia), .wr_collide(col_n));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mem [32];
   bit          bsy [32];
   bit          col_m;

   task automatic m_reset();
      for (int r = 0; r < 32; r++) begin
         mem[r] = '0;
         bsy[r] = 1'b0;
      end
      col_m = 1'b0;
   endtask

   function automatic bit m_writing(input logic [4:0] a);
      return (we[1] && wa1 == a) || (we[0] && wa0 == a);
   endfunction

   function automatic logic [31:0] m_data(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && we[1] && wa1 == a) return wd1;
      if (byp && we[0] && wa0 == a) return wd0;
      return mem[a];
   endfunction

   function automatic bit m_busy(input logic [4:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && m_writing(a)) return 1'b0;
      return bsy[a];
   endfunction

   // Apply the current inputs as one clock edge.
   task automatic m_commit();
      for (int r = 1; r < 32; r++) begin
         if (ie && ia == 5'(r)) bsy[r] = 1'b1;
         else if (m_writing(5'(r))) bsy[r] = 1'b0;
      end
      col_m = (we == 2'b11) && (wa0 == wa1) && (wa0 != 0);
      if (we[0] && wa0 != 0) mem[wa0] = wd0;
      if (we[1] && wa1 != 0) mem[wa1] = wd1;
   endtask

   task automatic idle();
      we = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ie = 1'b0; ia = '0;
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_b%0d_data", tag, k), rd_data_b[k*DW +: DW], m_data(ra[k], 1'b1));
         chk($sformatf("%s_b%0d_busy", tag, k), {31'b0, rd_busy_b[k]}, {31'b0, m_busy(ra[k], 1'b1)});
      end
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_n%0d_data", tag, k), rd_data_n[k*DW +: DW], m_data(ra[k], 1'b0));
         chk($sformatf("%s_n%0d_busy", tag, k), {31'b0, rd_busy_n[k]}, {31'b0, m_busy(ra[k], 1'b0)});
      end
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        ie;
      logic [4:0]  ia;
      logic [4:0]  ra;
      logic [31:0] d_b_pre;
      logic [31:0] d_n_pre;
      logic [31:0] d_post;
      logic        bb_pre;
      logic        bn_pre;
      logic        bb_post;
      logic        bn_post;
      logic        col;
   } vec_t;

   vec_t tbl [13];
   logic prev_col;

   initial begin
      tbl[0]  = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7,
                  32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{2'b11, 5'd9, 32'h1111, 5'd9, 32'h2222,  1'b0, 5'd0, 5'd9,
                  32'h2222, 32'h0, 32'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9,
                  32'h2222, 32'h2222, 32'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{2'b11, 5'd0, 32'h5, 5'd0, 32'h6,  1'b0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,
                  32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'hA5,  1'b1, 5'd3, 5'd3,
                  32'hA5, 32'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,
                  32'hA5, 32'hA5, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{2'b01, 5'd3, 32'hB6, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,
                  32'hB6, 32'hA5, 32'hB6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,
                  32'hB6, 32'hB6, 32'hB6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{2'b01, 5'd5, 32'h55, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5,
                  32'h55, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset held: reads of 5 and 31 return zero, not busy.
      rst_n = 1'b0;
      idle();
      ra[0] = 5'd5; ra[1] = 5'd31; ra[2] = 5'd5; ra[3] = 5'd31;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         chk($sformatf("rst_b%0d_data", k), rd_data_b[k*DW +: DW], 32'h0);
      chk("rst_b_busy", {28'b0, rd_busy_b}, 32'h0);
      chk("rst_n_data", rd_data_n[DW-1:0], 32'h0);
      chk("rst_n_busy", {30'b0, rd_busy_n}, 32'h0);
      chk("rst_col", {31'b0, col_b}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: check before the edge, then after it with inputs held.
      prev_col = 1'b0;
      for (int i = 0; i < 13; i++) begin
         we = tbl[i].we; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
         wa1 = tbl[i].wa1; wd1 = tbl[i].wd1; ie = tbl[i].ie; ia = tbl[i].ia;
         for (int k = 0; k < 4; k++) ra[k] = tbl[i].ra;
         #2;
         chk($sformatf("v%0d_b_data_pre", i), rd_data_b[DW-1:0], tbl[i].d_b_pre);
         chk($sformatf("v%0d_n_data_pre", i), rd_data_n[DW-1:0], tbl[i].d_n_pre);
         chk($sformatf("v%0d_b_busy_pre", i), {31'b0, rd_busy_b[0]}, {31'b0, tbl[i].bb_pre});
         chk($sformatf("v%0d_n_busy_pre", i), {31'b0, rd_busy_n[0]}, {31'b0, tbl[i].bn_pre});
         chk($sformatf("v%0d_col_pre", i), {31'b0, col_b}, {31'b0, prev_col});
         @(posedge clk);
         m_commit();
         #1;
         chk($sformatf("v%0d_b_data_post", i), rd_data_b[DW-1:0], tbl[i].d_post);
         chk($sformatf("v%0d_n_data_post", i), rd_data_n[DW-1:0], tbl[i].d_post);
         chk($sformatf("v%0d_b_busy_post", i), {31'b0, rd_busy_b[0]}, {31'b0, tbl[i].bb_post});
         chk($sformatf("v%0d_n_busy_post", i), {31'b0, rd_busy_n[0]}, {31'b0, tbl[i].bn_post});
         chk($sformatf("v%0d_b_col", i), {31'b0, col_b}, {31'b0, tbl[i].col});
         chk($sformatf("v%0d_n_col", i), {31'b0, col_n}, {31'b0, tbl[i].col});
         prev_col = tbl[i].col;
      end

      // Reset mid-operation: busy r4 and r6, r6 = 0x77, then async reset.
      idle(); ie = 1'b1; ia = 5'd4;
      @(posedge clk); m_commit(); #1;
      idle(); ie = 1'b1; ia = 5'd6;
      @(posedge clk); m_commit(); #1;
      idle(); we = 2'b01; wa0 = 5'd6; wd0 = 32'h77; ie = 1'b1; ia = 5'd6;
      @(posedge clk); m_commit(); #1;
      idle();
      ra[0] = 5'd6; ra[1] = 5'd4; ra[2] = 5'd6; ra[3] = 5'd4;
      #1;
      chk("mid_r6_data", rd_data_b[0*DW +: DW], 32'h77);
      chk("mid_r4_data", rd_data_b[1*DW +: DW], 32'h0);
      chk("mid_busy", {28'b0, rd_busy_b}, 32'hF);
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++)
         chk($sformatf("mid_rst_b%0d_data", k), rd_data_b[k*DW +: DW], 32'h0);
      chk("mid_rst_b_busy", {28'b0, rd_busy_b}, 32'h0);
      chk("mid_rst_n_data0", rd_data_n[DW-1:0], 32'h0);
      chk("mid_rst_n_busy", {30'b0, rd_busy_n}, 32'h0);
      // A write presented during reset is neither bypassed nor stored.
      we = 2'b01; wa0 = 5'd4; wd0 = 32'h99;
      #1;
      chk("mid_rst_nobyp", rd_data_b[1*DW +: DW], 32'h0);
      @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      m_reset();
      #1;
      chk("post_rst_r4_b", rd_data_b[1*DW +: DW], 32'h0);
      chk("post_rst_r4_n", rd_data_n[1*DW +: DW], 32'h0);
      chk("post_rst_busy", {28'b0, rd_busy_b}, 32'h0);
      chk("post_rst_col", {31'b0, col_b}, 32'h0);
      @(posedge clk); m_commit(); #1;

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         we  = 2'($urandom_range(0, 3));
         wa0 = rnd_addr();
         wa1 = ($urandom_range(0, 5) == 0) ? wa0 : rnd_addr();
         wd0 = $urandom();
         wd1 = $urandom();
         ie  = 1'($urandom_range(0, 1));
         ia  = rnd_addr();
         for (int k = 0; k < 4; k++) ra[k] = rnd_addr();
         #2;
         check_all($sformatf("rnd%0d", c));
         @(posedge clk);
         m_commit();
         #1;
         chk($sformatf("rnd%0d_col_b", c), {31'b0, col_b}, {31'b0, col_m});
         chk($sformatf("rnd%0d_col_n", c), {31'b0, col_n}, {31'b0, col_m});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath.
- Provides NUM_RD combinational read ports and two clocked write ports (ALU writeback and load writeback).
- Includes an optional same-cycle write-to-read bypass and a per-register busy scoreboard used by the decode stage for hazard stall.
- Register 0 is hardwired to zero; all storage clears on reset.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >= 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a read returns the data being written this cycle; 0 = a read returns the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  read data, combinational; port k occupies bits [k*DW +: DW].
- rd_busy  out  NUM_RD  port k's register has a pending producer.
- wr_en  in  2  write enables, port 0 = ALU, port 1 = load.
- wr_addr  in  2*AW  write addresses.
- wr_data  in  2*DW  write data.
- iss_en  in  1  instruction issued with a destination register.
- iss_addr  in  AW  destination of the issued instruction.
- wr_collide  out  1  registered flag: both write ports targeted the same nonzero address last cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers go to 0, all busy bits go to 0, wr_collide goes to 0.
  - rd_data therefore reads 0 and rd_busy reads 0 while reset is held.
  - Reset asserted mid-write discards that write.
- Register 0:
  - Reads return 0.
  - Writes to address 0 are ignored.
  - Issue to address 0 is ignored; busy[0] is always 0.
- Write, on the rising clk edge:
  - For each port i, if wr_en[i] and the address is nonzero, the register is updated.
  - If both ports target the same address in the same cycle, port 1 wins.
  - wr_collide is 1 in the following cycle only, and only when the shared address is nonzero.
- Read (combinational, zero latency):
  - rd_data[k] = 0 if the address is 0.
  - Otherwise, if BYPASS=1 and a port is writing that address this cycle, rd_data[k] = that port's wr_data (port 1 has priority).
  - Otherwise rd_data[k] = the stored value.
  - With BYPASS=0, the new value becomes visible the cycle after the edge.
- Scoreboard, per register r != 0, on the rising clk edge:
  - Set busy[r] when iss_en and iss_addr == r.
  - Clear busy[r] when any write port writes r.
  - Set and clear in the same cycle on the same r: busy stays 1, because the new producer wins.
  - Issue to an already-busy register: stays 1.
  - A writeback to a non-busy register is a legal write; busy stays 0.
- rd_busy[k]:
  - 0 if the address is 0.
  - If BYPASS=1: busy[addr] and no write port is writing addr this cycle.
  - If BYPASS=0: busy[addr].
- rd_addr is out-of-range only if DEPTH is not a power of two, which is illegal; an elaboration-time assertion rejects it.
- No other latency: one-cycle write, zero-cycle read.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO address constant.
  - Port-index constants WB_ALU = 0 and WB_LOAD = 1.
  - Function clog2 for tool compatibility.
- One natural sub-module: regfile_rd_port.
  - Handles the zero check, bypass mux and busy qualification for one read port.
  - Instantiated NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset and zero register:
  - Stimulus: hold rst_n=0, read addresses 5 and 31; release, write 0xDEADBEEF to r0 via port 0, then read r0.
  - Required: reads of 5 and 31 return 0 and rd_busy=0; r0 reads 0 and wr_collide=0.
- Write/read with BYPASS=1:
  - Stimulus: port 0 writes r7=0x12345678 while rd_addr[0]=7 in the same cycle.
  - Required: rd_data[0]=0x12345678 before the edge; still 0x12345678 after.
- Write/read with BYPASS=0:
  - Stimulus: the same write as above.
  - Required: rd_data[0] holds the old value (0) in the write cycle and becomes 0x12345678 in the next cycle.
- Dual-write collision:
  - Stimulus: port 0 writes r9=0x1111, port 1 writes r9=0x2222 in the same cycle.
  - Required: r9 reads 0x2222; wr_collide=1 for exactly one cycle.
  - Repeat with both ports targeting r0: r0 reads 0 and wr_collide stays 0.
- Scoreboard:
  - Stimulus: issue r3; next cycle read r3; then port 1 writes r3=0xA5 while iss_addr=3.
  - Required: rd_busy=1 after the issue; after the same-cycle write and reissue, busy stays 1 and r3 reads 0xA5.
  - Stimulus: a write to r3 with no issue.
  - Required: busy=0.
- Reset mid-operation, NUM_RD=4:
  - Stimulus: busy r4 and r6, write r6=0x77, assert rst_n low between clock edges.
  - Required: all four read ports return 0 and rd_busy=4'b0000 immediately, without waiting for clk.
